// File: rtl/traffic_sensor_if.sv
// Sensor/controller bundle for traffic_sensor: arrival pulses and light states in, queue counts and flags out.
// The sensor consumes the slave modport; whoever drives the sensors and reads the counts uses master.
interface traffic_sensor_if;
    logic       m_arrive;
    logic       l_arrive;
    logic       s_arrive;
    logic       p_arrive;
    logic       siren;
    logic [3:0] m_LRYG;
    logic [2:0] s_RYG;
    logic       ped;

    logic [2:0] main_num;
    logic [2:0] left_num;
    logic [2:0] sec_num;
    logic [2:0] p_num;
    logic       m_more;
    logic       s_more;
    logic       p_more;
    logic       l_zero;
    logic [2:0] absolute_num;
    logic       s_emergency;

    modport master (
        output m_arrive, l_arrive, s_arrive, p_arrive, siren, m_LRYG, s_RYG, ped,
        input  main_num, left_num, sec_num, p_num, m_more, s_more, p_more,
               l_zero, absolute_num, s_emergency
    );

    modport slave (
        input  m_arrive, l_arrive, s_arrive, p_arrive, siren, m_LRYG, s_RYG, ped,
        output main_num, left_num, sec_num, p_num, m_more, s_more, p_more,
               l_zero, absolute_num, s_emergency
    );
endinterface

// File: rtl/traffic_sensor.sv
// Per-lane queue counters (main, left, secondary, pedestrian) drained while the lane shows green.
// Define TRAFFIC_SENSOR_EMERG_DET_EN to compile in the siren qualifier driving s_emergency.
module traffic_sensor #(
    parameter int DEPART_CYC = 4,
    parameter int MORE_TH    = 5,
    parameter int EMERG_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    traffic_sensor_if.slave   sensor_if
);

    localparam int         NL       = 4;
    localparam logic [3:0] DEP_LAST = 4'(DEPART_CYC - 1);
    localparam logic [2:0] MORE_V   = 3'(MORE_TH);
    localparam logic [3:0] HOLD_V   = 4'(EMERG_HOLD);
    localparam logic [2:0] CNT_MAX  = 3'd7;

    // Lane index order: 0 main, 1 left, 2 secondary, 3 pedestrian.
    logic [NL-1:0]      green;
    logic [NL-1:0]      arrive;
    logic [NL-1:0][2:0] cnt;

    assign green  = {sensor_if.ped, sensor_if.s_RYG[0], sensor_if.m_LRYG[3], sensor_if.m_LRYG[0]};
    assign arrive = {sensor_if.p_arrive, sensor_if.s_arrive, sensor_if.l_arrive, sensor_if.m_arrive};

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic [3:0] tmr_q, tmr_d;
        logic [2:0] cnt_q, cnt_d;
        logic       depart;

        always_comb begin
            tmr_d  = '0;
            depart = 1'b0;
            if (green[i]) begin
                if (tmr_q == DEP_LAST) begin
                    depart = 1'b1;
                end else begin
                    tmr_d = tmr_q + 4'd1;
                end
            end
        end

        // Coincident arrive and depart cancel, even at the 0 and 7 limits.
        always_comb begin
            cnt_d = cnt_q;
            case ({arrive[i], depart})
                2'b10: if (cnt_q != CNT_MAX) cnt_d = cnt_q + 3'd1;
                2'b01: if (cnt_q != 3'd0)    cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tmr_q <= '0;
                cnt_q <= '0;
            end else begin
                tmr_q <= tmr_d;
                cnt_q <= cnt_d;
            end
        end

        assign cnt[i] = cnt_q;
    end

    assign sensor_if.main_num     = cnt[0];
    assign sensor_if.left_num     = cnt[1];
    assign sensor_if.sec_num      = cnt[2];
    assign sensor_if.p_num        = cnt[3];
    assign sensor_if.m_more       = (cnt[0] >= MORE_V);
    assign sensor_if.s_more       = (cnt[2] >= MORE_V);
    assign sensor_if.p_more       = (cnt[3] >= MORE_V);
    assign sensor_if.l_zero       = (cnt[1] == 3'd0);
    assign sensor_if.absolute_num = {cnt[0] == CNT_MAX, cnt[2] == CNT_MAX, cnt[1] == CNT_MAX};

    // Only the green bits of the light vectors matter here.
    logic [3:0] unused_lights;
    assign unused_lights = {sensor_if.m_LRYG[2:1], sensor_if.s_RYG[2:1]};

`ifdef TRAFFIC_SENSOR_EMERG_DET_EN
    logic [3:0] run_q, run_d;
    logic       emerg_q;

    always_comb begin
        run_d = '0;
        if (sensor_if.siren) begin
            run_d = (run_q == HOLD_V) ? run_q : run_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= '0;
            emerg_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            emerg_q <= (run_q == HOLD_V);
        end
    end

    assign sensor_if.s_emergency = emerg_q;
`else
    logic [4:0] unused_emerg;
    assign unused_emerg          = {sensor_if.siren, HOLD_V};
    assign sensor_if.s_emergency = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_sensor.sv
// Directed plus randomized checks of traffic_sensor against a queue-length model driven by green run lengths.
module tb_traffic_sensor;

  localparam int DEPART_CYC = 4;
  localparam int MORE_TH    = 5;
  localparam int EMERG_HOLD = 8;

  logic clk;
  logic rst;
  traffic_sensor_if tsif();

  traffic_sensor #(
    .DEPART_CYC (DEPART_CYC),
    .MORE_TH    (MORE_TH),
    .EMERG_HOLD (EMERG_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_if (tsif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: queue lengths, consecutive-green lengths, siren run length
  int q_len[4];
  int green_run[4];
  int siren_run;
  bit exp_emerg;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q_len[i]     = 0;
      green_run[i] = 0;
    end
    siren_run = 0;
    exp_emerg = 1'b0;
  endtask

  task automatic model_edge();
    bit arr[4];
    bit grn[4];
    bit dep;
    arr = '{tsif.m_arrive, tsif.l_arrive, tsif.s_arrive, tsif.p_arrive};
    grn = '{tsif.m_LRYG[0], tsif.m_LRYG[3], tsif.s_RYG[0], tsif.ped};
    for (int i = 0; i < 4; i++) begin
      green_run[i] = grn[i] ? green_run[i] + 1 : 0;
      dep = grn[i] && (green_run[i] % DEPART_CYC == 0);
      if (arr[i] && !dep)      q_len[i] = (q_len[i] < 7) ? q_len[i] + 1 : 7;
      else if (dep && !arr[i]) q_len[i] = (q_len[i] > 0) ? q_len[i] - 1 : 0;
    end
`ifdef TRAFFIC_SENSOR_EMERG_DET_EN
    exp_emerg = (siren_run >= EMERG_HOLD);
    siren_run = tsif.siren ? siren_run + 1 : 0;
`else
    exp_emerg = 1'b0;
`endif
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    chk("main_num", tsif.main_num, 8'(q_len[0]));
    chk("left_num", tsif.left_num, 8'(q_len[1]));
    chk("sec_num",  tsif.sec_num,  8'(q_len[2]));
    chk("p_num",    tsif.p_num,    8'(q_len[3]));
    chk("m_more",   tsif.m_more,   8'(q_len[0] >= MORE_TH));
    chk("s_more",   tsif.s_more,   8'(q_len[2] >= MORE_TH));
    chk("p_more",   tsif.p_more,   8'(q_len[3] >= MORE_TH));
    chk("l_zero",   tsif.l_zero,   8'(q_len[1] == 0));
    chk("absolute_num", tsif.absolute_num,
        {5'b0, q_len[0] == 7, q_len[2] == 7, q_len[1] == 7});
    chk("s_emergency", tsif.s_emergency, 8'(exp_emerg));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_arrivals(input bit m, input bit l, input bit s, input bit p);
    tsif.m_arrive = m;
    tsif.l_arrive = l;
    tsif.s_arrive = s;
    tsif.p_arrive = p;
  endtask

  task automatic all_red();
    tsif.m_LRYG = 4'b0100;
    tsif.s_RYG  = 3'b100;
    tsif.ped    = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    tsif.siren = 1'b0;
    set_arrivals(0, 0, 0, 0);
    all_red();
    model_reset();
    #23;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // three main arrivals with main red
    for (int n = 0; n < 3; n++) begin
      set_arrivals(1, 0, 0, 0);
      tick();
    end
    set_arrivals(0, 0, 0, 0);
    tick();
    chk("main_three", tsif.main_num, 8'd3);

    // secondary saturates at 7
    for (int n = 0; n < 9; n++) begin
      set_arrivals(0, 0, 1, 0);
      tick();
    end
    set_arrivals(0, 0, 0, 0);
    tick();
    chk("sec_sat", tsif.sec_num, 8'd7);
    chk("abs_sec", tsif.absolute_num, 8'b010);

    // main up to 5, then 12 green cycles drain three vehicles
    for (int n = 0; n < 2; n++) begin
      set_arrivals(1, 0, 0, 0);
      tick();
    end
    set_arrivals(0, 0, 0, 0);
    chk("main_five", tsif.main_num, 8'd5);
    tsif.m_LRYG = 4'b0001;
    for (int n = 0; n < 12; n++) tick();
    chk("main_drained", tsif.main_num, 8'd2);
    chk("m_more_low", tsif.m_more, 8'd0);

    // left: arrival coincident with depart at zero, then a lone arrival
    tsif.m_LRYG = 4'b1100;
    for (int n = 0; n < 3; n++) tick();
    set_arrivals(0, 1, 0, 0);
    tick();
    chk("left_cancel", tsif.left_num, 8'd0);
    tick();
    chk("left_one", tsif.left_num, 8'd1);
    chk("l_zero_low", tsif.l_zero, 8'd0);
    set_arrivals(0, 0, 0, 0);
    all_red();
    tick();

    // siren: 7 high, 1 low, 8 high, then low
    tsif.siren = 1'b1;
    for (int n = 0; n < 7; n++) tick();
    tsif.siren = 1'b0;
    tick();
    tsif.siren = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    tsif.siren = 1'b0;
    for (int n = 0; n < 3; n++) tick();

    // randomized traffic with sticky lights
    for (int n = 0; n < 400; n++) begin
      set_arrivals($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: tsif.m_LRYG = 4'b0100;
          1: tsif.m_LRYG = 4'b0001;
          2: tsif.m_LRYG = 4'b0010;
          default: tsif.m_LRYG = 4'b1100;
        endcase
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: tsif.s_RYG = 3'b100;
          1: tsif.s_RYG = 3'b001;
          default: tsif.s_RYG = 3'b010;
        endcase
      end
      if ($urandom_range(0, 5) == 0) tsif.ped = ~tsif.ped;
      if ($urandom_range(0, 7) == 0) tsif.siren = ~tsif.siren;
      tick();
    end

    // build nonzero counts, then async reset between edges
    all_red();
    tsif.siren = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_arrivals(1, 1, 1, 1);
      tick();
    end
    set_arrivals(0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      set_arrivals(1, 0, 0, 1);
      tick();
    end
    set_arrivals(0, 0, 0, 0);
    tick();
    chk("post_reset_main", tsif.main_num, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
